// File: rtl/mips_pc_sequencer.sv
// Program-counter sequencer for the single-cycle mips core: holds prog_ctr for a
// settle window, then commits updated_pc under run/step/halt/breakpoint/limit control.
module mips_pc_sequencer #(
    parameter int          SETTLE_CYCLES = 3,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [CNT_W-1:0] max_instr,
    input  logic [31:0]      updated_pc,
    output logic [31:0]      prog_ctr,
    output logic             commit,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t            state_r;
    logic [SC_W-1:0]   settle_cnt_r;
    logic              step_mode_r;
    logic              halt_pend_r;

    logic [CNT_W-1:0]  count_inc_s;
    logic              misaligned_s;
    logic              stop_s;
    logic [1:0]        stop_cause_s;

    // The counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decide whether the commit in progress stops the sequencer, and why.
    always_comb begin
        count_inc_s  = sat_inc(instr_count);
        misaligned_s = (updated_pc[1:0] != 2'b00);
        stop_s       = 1'b0;
        stop_cause_s = 2'd0;
        if (misaligned_s) begin
            stop_s       = 1'b1;
            stop_cause_s = 2'd3;
        end else if (bp_en && (updated_pc == bp_addr)) begin
            stop_s       = 1'b1;
            stop_cause_s = 2'd1;
        end else if ((max_instr != {CNT_W{1'b0}}) && (count_inc_s == max_instr)) begin
            stop_s       = 1'b1;
            stop_cause_s = 2'd2;
        end else if (halt_pend_r || halt_req || step_mode_r) begin
            stop_s       = 1'b1;
            stop_cause_s = 2'd0;
        end else begin
            stop_s       = 1'b0;
            stop_cause_s = 2'd0;
        end
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SC_W{1'b0}};
            step_mode_r  <= 1'b0;
            halt_pend_r  <= 1'b0;
            prog_ctr     <= RESET_PC;
            commit       <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            halt_cause   <= 2'd0;
            instr_count  <= {CNT_W{1'b0}};
        end else begin
            commit <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (start || step) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= SETTLE_LOAD;
                        step_mode_r  <= step;
                        halt_pend_r  <= 1'b0;
                        busy         <= 1'b1;
                        halted       <= 1'b0;
                        halt_cause   <= 2'd0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r != {SC_W{1'b0}}) begin
                        settle_cnt_r <= settle_cnt_r - SC_W'(1);
                        if (halt_req) begin
                            halt_pend_r <= 1'b1;
                        end
                    end else begin
                        // A misaligned target is rejected without touching PC or count.
                        if (!misaligned_s) begin
                            prog_ctr    <= updated_pc;
                            instr_count <= count_inc_s;
                            commit      <= 1'b1;
                        end
                        if (stop_s) begin
                            state_r     <= ST_HALTED;
                            busy        <= 1'b0;
                            halted      <= 1'b1;
                            halt_cause  <= stop_cause_s;
                            halt_pend_r <= 1'b0;
                        end else begin
                            settle_cnt_r <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Self-checking bench for mips_pc_sequencer: directed sequences, a table of
// halt scenarios, and randomized control traffic against a behavioural model.
module tb_mips_pc_sequencer;

    localparam int S = 3;

    logic        clock;
    logic        reset_n;
    logic        start, step, halt_req, bp_en;
    logic [31:0] bp_addr, max_instr, updated_pc, prog_ctr, instr_count;
    logic [31:0] pc_off;
    logic        commit, busy, halted;
    logic [1:0]  halt_cause;

    int n_tests = 0;
    int n_fail  = 0;

    // Core stand-in: next PC is the current PC plus a bench-controlled offset.
    assign updated_pc = prog_ctr + pc_off;

    mips_pc_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .max_instr(max_instr), .updated_pc(updated_pc), .prog_ctr(prog_ctr),
        .commit(commit), .busy(busy), .halted(halted),
        .halt_cause(halt_cause), .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 executing, 2 stopped; age = cycles into the instruction.
    int          m_mode, m_age;
    logic [31:0] m_pc, m_cnt;
    logic [1:0]  m_cause;
    bit          m_commit, m_step, m_pend;

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_pc = 32'h0; m_cnt = 32'h0;
        m_cause = 2'd0; m_commit = 1'b0; m_step = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_stop(input logic [1:0] c);
        m_mode = 2; m_cause = c; m_pend = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        m_commit = 1'b0;
        if (m_mode != 1) begin
            if (start || step) begin
                m_mode = 1; m_age = 0; m_step = step; m_pend = 1'b0; m_cause = 2'd0;
            end
        end else begin
            m_age++;
            if (halt_req) m_pend = 1'b1;
            if (m_age == S) begin
                nxt = m_pc + pc_off;
                if (nxt[1:0] != 2'b00) begin
                    model_stop(2'd3);
                end else begin
                    m_pc = nxt;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                    m_commit = 1'b1;
                    if (bp_en && nxt == bp_addr) model_stop(2'd1);
                    else if (max_instr != 32'd0 && m_cnt == max_instr) model_stop(2'd2);
                    else if (m_pend || m_step) model_stop(2'd0);
                    else m_age = 0;
                end
            end
        end
    endtask

    typedef struct {
        bit          do_step;
        bit          bp_en;
        logic [31:0] bp_addr;
        logic [31:0] max_instr;
        logic [31:0] off;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic [1:0]  e_cause;
        int          e_commits;
    } vec_t;

    vec_t tbl[5];

    task automatic do_reset();
        start = 1'b0; step = 1'b0; halt_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int commits;
        bit seen;
        start = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h0; max_instr = 32'h0; pc_off = 32'd4; reset_n = 1'b0;
        #1;
        check("reset_outputs", {prog_ctr, commit, busy, halted, halt_cause, instr_count},
              {32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0});
        do_reset();

        // Run: PC advances by 4 every S cycles, then a mid-settle halt_req stops it.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("run_pc_%0d", i), prog_ctr, 32'd4 * (i / S));
            check($sformatf("run_commit_%0d", i), commit, (i > 0 && i % S == 0));
            check($sformatf("run_busy_%0d", i), busy, 1'b1);
            if (i < 10) @(negedge clock);
        end
        halt_req = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        check("halt_req_pending", {prog_ctr, halted}, {32'd12, 1'b0});
        @(negedge clock);
        check("halt_req_stop", {prog_ctr, commit, busy, halted, halt_cause, instr_count},
              {32'd16, 1'b1, 1'b0, 1'b1, 2'd0, 32'd4});

        // Asynchronous reset in the middle of a settle window.
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_now", {prog_ctr, commit, busy, halted, halt_cause, instr_count},
              {32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0});
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (commit) seen = 1'b1;
        end
        check("async_reset_no_commit", {seen, prog_ctr}, {1'b0, 32'h0});
        reset_n = 1'b1;
        @(negedge clock);

        // Table: each command runs until halted; final state compared against the row.
        tbl[0] = '{1, 0, 32'h00, 32'd0, 32'd4, 32'h04, 32'd1, 2'd0, 1};
        tbl[1] = '{1, 0, 32'h00, 32'd0, 32'd4, 32'h08, 32'd2, 2'd0, 1};
        tbl[2] = '{0, 1, 32'h10, 32'd0, 32'd4, 32'h10, 32'd4, 2'd1, 2};
        tbl[3] = '{0, 1, 32'h10, 32'd6, 32'd4, 32'h18, 32'd6, 2'd2, 2};
        tbl[4] = '{0, 0, 32'h00, 32'd0, 32'd2, 32'h18, 32'd6, 2'd3, 0};
        foreach (tbl[r]) begin
            bp_en = tbl[r].bp_en; bp_addr = tbl[r].bp_addr;
            max_instr = tbl[r].max_instr; pc_off = tbl[r].off;
            step = tbl[r].do_step; start = !tbl[r].do_step;
            @(negedge clock);
            step = 1'b0; start = 1'b0;
            commits = 0; seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (commit) commits++;
                if (halted) begin seen = 1'b1; break; end
                @(negedge clock);
            end
            check($sformatf("tbl%0d_halted", r), seen, 1'b1);
            check($sformatf("tbl%0d_pc", r), prog_ctr, tbl[r].e_pc);
            check($sformatf("tbl%0d_count", r), instr_count, tbl[r].e_cnt);
            check($sformatf("tbl%0d_cause", r), halt_cause, tbl[r].e_cause);
            check($sformatf("tbl%0d_busy", r), busy, 1'b0);
            check($sformatf("tbl%0d_commits", r), commits, tbl[r].e_commits);
        end

        // Randomized control traffic against the model.
        bp_en = 1'b0; max_instr = 32'd0; pc_off = 32'd4;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clock);
            if (reset_n) model_step();
            @(negedge clock);
            check($sformatf("rand_%0d", cyc),
                  {prog_ctr, commit, busy, halted, halt_cause, instr_count},
                  {m_pc, m_commit, (m_mode == 1), (m_mode == 2), m_cause, m_cnt});
            reset_n  = 1'b1;
            start    = ($urandom_range(0, 7) == 0);
            step     = ($urandom_range(0, 9) == 0);
            halt_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 15) == 0) bp_addr = 32'd4 * $urandom_range(0, 15);
            if ($urandom_range(0, 31) == 0) max_instr = $urandom_range(0, 40);
            case ($urandom_range(0, 9))
                0: pc_off = 32'hFFFF_FFF8;
                1: pc_off = 32'd2;
                2: pc_off = 32'd8;
                default: pc_off = 32'd4;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
